// File: rtl/gb_board_painter.sv
// gb_board_painter: write-side master for the 12-bit RGB444 framebuffer.
// Turns game-logic drawing commands (clear board, place stone, erase stone)
// into a gap-free stream of single-pixel writes, one per clock. All outputs
// are registered. Each output is computed from the next-state and next-counter
// values, so the first pixel appears on the cycle after a command is accepted.
module gb_board_painter #(
    parameter int DW   = 15,
    parameter int FB_W = 200,
    parameter int FB_H = 150,
    parameter int X0   = 40,
    parameter int Y0   = 15
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_op,
    input  logic [3:0]    cmd_x,
    input  logic [3:0]    cmd_y,
    input  logic          cmd_color,
    output logic [DW-1:0] waddr,
    output logic [11:0]   wdata,
    output logic          we,
    output logic          busy,
    output logic          done,
    output logic          cmd_err
);

    // Counter widths cover every pixel coordinate of the framebuffer.
    localparam int XW = $clog2(FB_W);
    localparam int YW = $clog2(FB_H);

    // The board is 15 cells of 8 pixels in each direction.
    localparam int BOARD_PIX = 120;

    localparam logic [XW-1:0] PX_LAST = XW'(FB_W - 1);
    localparam logic [YW-1:0] PY_LAST = YW'(FB_H - 1);
    localparam logic [XW-1:0] BX_LO   = XW'(X0);
    localparam logic [XW-1:0] BX_HI   = XW'(X0 + BOARD_PIX);
    localparam logic [YW-1:0] BY_LO   = YW'(Y0);
    localparam logic [YW-1:0] BY_HI   = YW'(Y0 + BOARD_PIX);

    // Command opcodes.
    localparam logic [1:0] OP_CLEAR = 2'b00;
    localparam logic [1:0] OP_PLACE = 2'b01;
    localparam logic [1:0] OP_ERASE = 2'b10;

    // Colours.
    localparam logic [11:0] C_GRID   = 12'h000;
    localparam logic [11:0] C_BOARD  = 12'hDA6;
    localparam logic [11:0] C_BORDER = 12'h333;
    localparam logic [11:0] C_BLACK  = 12'h111;
    localparam logic [11:0] C_WHITE  = 12'hEEE;

    // FSM states.
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CLEAR = 2'd1;
    localparam logic [1:0] S_CELL  = 2'd2;
    localparam logic [1:0] S_FIN   = 2'd3;

    // Cell background: grid lines on column 3 and row 3 of every cell.
    function automatic logic [11:0] cell_bg(input logic [2:0] dx, input logic [2:0] dy);
        logic [11:0] c;
        if ((dx == 3'd3) || (dy == 3'd3)) begin
            c = C_GRID;
        end else begin
            c = C_BOARD;
        end
        return c;
    endfunction

    // Stone shape: an 8x8 square with its corners rounded off.
    function automatic logic stone_inside(input logic [2:0] dx, input logic [2:0] dy);
        logic edge_row;
        logic near_row;
        logic outer_col;
        logic edge_col;
        edge_row  = (dy == 3'd0) || (dy == 3'd7);
        near_row  = (dy == 3'd1) || (dy == 3'd6);
        outer_col = (dx == 3'd0) || (dx == 3'd7);
        edge_col  = outer_col || (dx == 3'd1) || (dx == 3'd6);
        return !((edge_row && edge_col) || (near_row && outer_col));
    endfunction

    // Registered state and counters. In CLEAR, cdx/cdy track the position inside
    // the current board cell; in CELL they are the dx/dy offsets directly.
    logic [1:0]    state;
    logic [XW-1:0] px;
    logic [YW-1:0] py;
    logic [2:0]    cdx;
    logic [2:0]    cdy;
    logic          op_place;
    logic          stone_white;
    logic          err_flag;

    // Next-state values.
    logic [1:0]    nstate;
    logic [XW-1:0] npx;
    logic [YW-1:0] npy;
    logic [2:0]    ncdx;
    logic [2:0]    ncdy;
    logic          nplace;
    logic          nwhite;
    logic          nerr;
    logic          n_in_board;
    logic          n_write;
    logic [11:0]   nwdata;
    logic [DW-1:0] naddr;

    // Next-state and counter sequencing for the raster walk.
    always_comb begin
        nstate = state;
        npx    = px;
        npy    = py;
        ncdx   = cdx;
        ncdy   = cdy;
        nplace = op_place;
        nwhite = stone_white;
        nerr   = err_flag;
        case (state)
            S_IDLE: begin
                if (cmd_valid) begin
                    nerr   = 1'b0;
                    nplace = (cmd_op == OP_PLACE);
                    nwhite = cmd_color;
                    ncdx   = 3'd0;
                    ncdy   = 3'd0;
                    if (cmd_op == OP_CLEAR) begin
                        nstate = S_CLEAR;
                        npx    = '0;
                        npy    = '0;
                    end else if (((cmd_op == OP_PLACE) || (cmd_op == OP_ERASE)) &&
                                 (cmd_x <= 4'd14) && (cmd_y <= 4'd14)) begin
                        nstate = S_CELL;
                        npx    = BX_LO + XW'({cmd_x, 3'b000});
                        npy    = BY_LO + YW'({cmd_y, 3'b000});
                    end else begin
                        nstate = S_FIN;
                        nerr   = 1'b1;
                    end
                end else begin
                    nstate = S_IDLE;
                end
            end
            S_CLEAR: begin
                if (px == PX_LAST) begin
                    if (py == PY_LAST) begin
                        nstate = S_FIN;
                    end else begin
                        npx  = '0;
                        npy  = py + YW'(1'b1);
                        ncdx = 3'd0;
                        if ((py + YW'(1'b1)) == BY_LO) begin
                            ncdy = 3'd0;
                        end else begin
                            ncdy = cdy + 3'd1;
                        end
                    end
                end else begin
                    npx = px + XW'(1'b1);
                    if ((px + XW'(1'b1)) == BX_LO) begin
                        ncdx = 3'd0;
                    end else begin
                        ncdx = cdx + 3'd1;
                    end
                end
            end
            S_CELL: begin
                if (cdx == 3'd7) begin
                    if (cdy == 3'd7) begin
                        nstate = S_FIN;
                    end else begin
                        npx  = px - XW'(3'd7);
                        npy  = py + YW'(1'b1);
                        ncdx = 3'd0;
                        ncdy = cdy + 3'd1;
                    end
                end else begin
                    npx  = px + XW'(1'b1);
                    ncdx = cdx + 3'd1;
                end
            end
            S_FIN: begin
                nstate = S_IDLE;
            end
            default: begin
                nstate = S_IDLE;
            end
        endcase
    end

    assign n_in_board = (npx >= BX_LO) && (npx < BX_HI) && (npy >= BY_LO) && (npy < BY_HI);
    assign n_write    = (nstate == S_CLEAR) || (nstate == S_CELL);
    assign naddr      = DW'(32'(npy) * 32'(FB_W) + 32'(npx));

    // Colour of the pixel that will be written next.
    always_comb begin
        nwdata = wdata;
        case (nstate)
            S_CLEAR: begin
                if (n_in_board) begin
                    nwdata = cell_bg(ncdx, ncdy);
                end else begin
                    nwdata = C_BORDER;
                end
            end
            S_CELL: begin
                if (nplace && stone_inside(ncdx, ncdy)) begin
                    nwdata = nwhite ? C_WHITE : C_BLACK;
                end else begin
                    nwdata = cell_bg(ncdx, ncdy);
                end
            end
            default: begin
                nwdata = wdata;
            end
        endcase
    end

    // State, counter and latched-command registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            px          <= '0;
            py          <= '0;
            cdx         <= 3'd0;
            cdy         <= 3'd0;
            op_place    <= 1'b0;
            stone_white <= 1'b0;
            err_flag    <= 1'b0;
        end else begin
            state       <= nstate;
            px          <= npx;
            py          <= npy;
            cdx         <= ncdx;
            cdy         <= ncdy;
            op_place    <= nplace;
            stone_white <= nwhite;
            err_flag    <= nerr;
        end
    end

    // Registered framebuffer port and handshake/status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            waddr     <= '0;
            wdata     <= 12'h000;
            we        <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            cmd_err   <= 1'b0;
            cmd_ready <= 1'b1;
        end else begin
            we        <= n_write;
            busy      <= n_write;
            done      <= (nstate == S_FIN);
            cmd_err   <= (nstate == S_FIN) && nerr;
            cmd_ready <= (nstate == S_IDLE);
            if (n_write) begin
                waddr <= naddr;
                wdata <= nwdata;
            end else begin
                waddr <= waddr;
                wdata <= wdata;
            end
        end
    end

endmodule

// File: tb/tb_gb_board_painter.sv
// Self-checking bench for gb_board_painter: a reference model pushes expected
// {address, colour} pairs when a command is issued; a monitor pops and compares
// them on every write cycle, and keeps an image of the written framebuffer.
module tb_gb_board_painter;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [3:0]  cmd_x;
    logic [3:0]  cmd_y;
    logic        cmd_color;
    logic [14:0] waddr;
    logic [11:0] wdata;
    logic        we;
    logic        busy;
    logic        done;
    logic        cmd_err;

    int checks;
    int failures;
    int n_writes;
    int cyc;
    int last_we_cyc;
    int rise_addr;
    int last_addr;
    logic prev_we;
    logic [26:0] exp_q[$];
    logic [11:0] mem [0:32767];

    gb_board_painter #(.DW(15), .FB_W(200), .FB_H(150), .X0(40), .Y0(15)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_color(cmd_color),
        .waddr(waddr), .wdata(wdata), .we(we), .busy(busy), .done(done),
        .cmd_err(cmd_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference colour of a board cell background pixel.
    function automatic logic [11:0] m_bg(int dx, int dy);
        if (dx == 3 || dy == 3) return 12'h000;
        return 12'hDA6;
    endfunction

    // Reference stone outline: rounded corners are outside the stone.
    function automatic bit m_outside(int dx, int dy);
        if ((dy == 0 || dy == 7) && (dx <= 1 || dx >= 6)) return 1'b1;
        if ((dy == 1 || dy == 6) && (dx == 0 || dx == 7)) return 1'b1;
        return 1'b0;
    endfunction

    task automatic push_clear();
        for (int y = 0; y < 150; y++) begin
            for (int x = 0; x < 200; x++) begin
                logic [11:0] c;
                if (x >= 40 && x < 160 && y >= 15 && y < 135) c = m_bg((x - 40) % 8, (y - 15) % 8);
                else c = 12'h333;
                exp_q.push_back({15'(y * 200 + x), c});
            end
        end
    endtask

    task automatic push_cell(bit place, bit white, int cx, int cy);
        for (int dy = 0; dy < 8; dy++) begin
            for (int dx = 0; dx < 8; dx++) begin
                logic [11:0] c;
                int a;
                a = (15 + 8 * cy + dy) * 200 + 40 + 8 * cx + dx;
                if (place && !m_outside(dx, dy)) c = white ? 12'hEEE : 12'h111;
                else c = m_bg(dx, dy);
                exp_q.push_back({15'(a), c});
            end
        end
    endtask

    // Write monitor: scoreboard compare, framebuffer image, timing bookkeeping.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (!rst && we) begin
            logic [26:0] e;
            n_writes = n_writes + 1;
            if (!prev_we) rise_addr = int'(waddr);
            last_addr = int'(waddr);
            last_we_cyc = cyc;
            mem[waddr] = wdata;
            checks = checks + 1;
            if (exp_q.size() == 0) begin
                failures = failures + 1;
                $display("FAIL unexpected_write got addr=%0d data=%h, expected no write", waddr, wdata);
            end else begin
                e = exp_q.pop_front();
                if ({waddr, wdata} !== e) begin
                    failures = failures + 1;
                    $display("FAIL write_stream got addr=%0d data=%h expected addr=%0d data=%h",
                             waddr, wdata, e[26:12], e[11:0]);
                end
            end
        end
        prev_we = !rst && we;
    end

    task automatic apply_reset();
        rst = 1'b1;
        cmd_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic send_cmd(logic [1:0] op, logic [3:0] x, logic [3:0] y, logic c);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk); #1;
            if (cmd_ready) begin ok = 1'b1; break; end
        end
        checks = checks + 1;
        if (!ok) begin
            failures = failures + 1;
            $display("FAIL cmd_ready_timeout got cmd_ready=%b expected 1", cmd_ready);
        end
        cmd_op = op; cmd_x = x; cmd_y = y; cmd_color = c; cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic wait_done(int budget, bit exp_err, bit had_writes);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk); #1;
            if (done) begin seen = 1'b1; break; end
        end
        checks = checks + 1;
        if (!seen) begin
            failures = failures + 1;
            $display("FAIL done_timeout got done=0 expected 1 within %0d cycles", budget);
            return;
        end
        checks = checks + 1;
        if ({cmd_err, busy, we} !== {exp_err, 1'b0, 1'b0}) begin
            failures = failures + 1;
            $display("FAIL done_cycle got err/busy/we=%b%b%b expected %b00", cmd_err, busy, we, exp_err);
        end
        if (had_writes) begin
            checks = checks + 1;
            if (cyc !== last_we_cyc + 1) begin
                failures = failures + 1;
                $display("FAIL done_latency got cycle=%0d expected %0d", cyc, last_we_cyc + 1);
            end
        end
        @(negedge clk); #1;
        checks = checks + 1;
        if ({cmd_ready, done, cmd_err} !== 3'b100) begin
            failures = failures + 1;
            $display("FAIL after_done got ready/done/err=%b%b%b expected 100", cmd_ready, done, cmd_err);
        end
    endtask

    task automatic test_reset();
        apply_reset();
        repeat (5) begin
            @(negedge clk); #1;
            checks = checks + 1;
            if ({we, cmd_ready, busy, done, cmd_err, waddr, wdata} !== {5'b01000, 15'd0, 12'h000}) begin
                failures = failures + 1;
                $display("FAIL reset_idle got we/rdy/busy/done/err=%b%b%b%b%b addr=%0d data=%h expected 01000 0 000",
                         we, cmd_ready, busy, done, cmd_err, waddr, wdata);
            end
        end
    endtask

    task automatic test_clear();
        int base;
        base = n_writes;
        push_clear();
        send_cmd(2'b00, 4'd0, 4'd0, 1'b0);
        checks = checks + 1;
        if ({busy, cmd_ready, we} !== 3'b101) begin
            failures = failures + 1;
            $display("FAIL clear_start got busy/rdy/we=%b%b%b expected 101", busy, cmd_ready, we);
        end
        wait_done(30100, 1'b0, 1'b1);
        checks = checks + 1;
        if (n_writes - base !== 30000) begin
            failures = failures + 1;
            $display("FAIL clear_count got %0d expected 30000", n_writes - base);
        end
        checks = checks + 1;
        if ({mem[0], mem[3040], mem[3043], mem[29999]} !== {12'h333, 12'hDA6, 12'h000, 12'h333}) begin
            failures = failures + 1;
            $display("FAIL clear_pixels got %h %h %h %h expected 333 da6 000 333",
                     mem[0], mem[3040], mem[3043], mem[29999]);
        end
        checks = checks + 1;
        if (rise_addr !== 0 || last_addr !== 29999) begin
            failures = failures + 1;
            $display("FAIL clear_range got first=%0d last=%0d expected 0 29999", rise_addr, last_addr);
        end
    endtask

    task automatic test_place_black();
        int base;
        base = n_writes;
        push_cell(1'b1, 1'b0, 0, 0);
        send_cmd(2'b01, 4'd0, 4'd0, 1'b0);
        wait_done(100, 1'b0, 1'b1);
        checks = checks + 1;
        if (n_writes - base !== 64 || rise_addr !== 3040) begin
            failures = failures + 1;
            $display("FAIL place_black_count got n=%0d first=%0d expected 64 3040", n_writes - base, rise_addr);
        end
        checks = checks + 1;
        if ({mem[3040], mem[3643], mem[3242], mem[3041]} !== {12'hDA6, 12'h111, 12'h111, 12'hDA6}) begin
            failures = failures + 1;
            $display("FAIL place_black_pixels got %h %h %h %h expected da6 111 111 da6",
                     mem[3040], mem[3643], mem[3242], mem[3041]);
        end
    endtask

    task automatic test_place_white();
        int base;
        base = n_writes;
        push_cell(1'b1, 1'b1, 14, 14);
        send_cmd(2'b01, 4'd14, 4'd14, 1'b1);
        wait_done(100, 1'b0, 1'b1);
        checks = checks + 1;
        if (n_writes - base !== 64 || rise_addr !== 25552 || last_addr !== 26959) begin
            failures = failures + 1;
            $display("FAIL place_white_range got n=%0d first=%0d last=%0d expected 64 25552 26959",
                     n_writes - base, rise_addr, last_addr);
        end
        checks = checks + 1;
        if (mem[26356] !== 12'hEEE) begin
            failures = failures + 1;
            $display("FAIL place_white_pixel got %h expected eee", mem[26356]);
        end
    endtask

    task automatic test_erase();
        int base;
        int blacks;
        base = n_writes;
        blacks = 0;
        push_cell(1'b0, 1'b1, 0, 0);
        send_cmd(2'b10, 4'd0, 4'd0, 1'b1);
        wait_done(100, 1'b0, 1'b1);
        for (int dy = 0; dy < 8; dy++)
            for (int dx = 0; dx < 8; dx++)
                if (mem[3040 + dy * 200 + dx] === 12'h111) blacks++;
        checks = checks + 1;
        if (n_writes - base !== 64 || blacks !== 0 || mem[3643] !== 12'h000) begin
            failures = failures + 1;
            $display("FAIL erase got n=%0d blacks=%0d px3643=%h expected 64 0 000",
                     n_writes - base, blacks, mem[3643]);
        end
    endtask

    task automatic test_invalid();
        int base;
        base = n_writes;
        send_cmd(2'b01, 4'd15, 4'd2, 1'b0);
        wait_done(10, 1'b1, 1'b0);
        send_cmd(2'b11, 4'd1, 4'd1, 1'b0);
        wait_done(10, 1'b1, 1'b0);
        send_cmd(2'b10, 4'd3, 4'd15, 1'b0);
        wait_done(10, 1'b1, 1'b0);
        checks = checks + 1;
        if (n_writes - base !== 0) begin
            failures = failures + 1;
            $display("FAIL invalid_writes got %0d expected 0", n_writes - base);
        end
    endtask

    task automatic test_back_to_back();
        int base;
        bit ok;
        base = n_writes;
        ok = 1'b0;
        push_cell(1'b1, 1'b1, 5, 7);
        push_cell(1'b1, 1'b0, 6, 7);
        send_cmd(2'b01, 4'd5, 4'd7, 1'b1);
        cmd_valid = 1'b1;
        cmd_x = 4'd6; cmd_color = 1'b0;
        @(negedge clk); #1;
        checks = checks + 1;
        if (cmd_ready !== 1'b0 || busy !== 1'b1) begin
            failures = failures + 1;
            $display("FAIL b2b_busy got rdy=%b busy=%b expected 0 1", cmd_ready, busy);
        end
        for (int i = 0; i < 200; i++) begin
            @(negedge clk); #1;
            if (cmd_ready) begin ok = 1'b1; break; end
        end
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        checks = checks + 1;
        if (!ok) begin
            failures = failures + 1;
            $display("FAIL b2b_ready_timeout got cmd_ready=0 expected 1");
        end
        wait_done(100, 1'b0, 1'b1);
        checks = checks + 1;
        if (n_writes - base !== 128 || exp_q.size() !== 0) begin
            failures = failures + 1;
            $display("FAIL b2b_count got n=%0d pending=%0d expected 128 0", n_writes - base, exp_q.size());
        end
        base = n_writes;
        push_clear();
        send_cmd(2'b00, 4'd0, 4'd0, 1'b0);
        repeat (500) @(negedge clk);
        cmd_op = 2'b01; cmd_x = 4'd3; cmd_y = 4'd3; cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        wait_done(30100, 1'b0, 1'b1);
        checks = checks + 1;
        if (n_writes - base !== 30000 || exp_q.size() !== 0) begin
            failures = failures + 1;
            $display("FAIL busy_ignore got n=%0d pending=%0d expected 30000 0", n_writes - base, exp_q.size());
        end
    endtask

    task automatic test_reset_mid_clear();
        int base;
        base = n_writes;
        push_clear();
        send_cmd(2'b00, 4'd0, 4'd0, 1'b0);
        for (int i = 0; i < 1100; i++) begin
            @(negedge clk); #1;
            if (n_writes - base >= 1000) break;
        end
        rst = 1'b1;
        #1;
        checks = checks + 1;
        if (we !== 1'b0 || n_writes - base !== 1000) begin
            failures = failures + 1;
            $display("FAIL reset_async got we=%b n=%0d expected 0 1000", we, n_writes - base);
        end
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        base = n_writes;
        repeat (20) @(negedge clk);
        #1;
        checks = checks + 1;
        if (cmd_ready !== 1'b1 || busy !== 1'b0 || we !== 1'b0 || n_writes - base !== 0) begin
            failures = failures + 1;
            $display("FAIL reset_recover got rdy=%b busy=%b we=%b n=%0d expected 1 0 0 0",
                     cmd_ready, busy, we, n_writes - base);
        end
    endtask

    initial begin
        checks = 0; failures = 0; n_writes = 0; cyc = 0;
        last_we_cyc = 0; rise_addr = -1; last_addr = -1; prev_we = 1'b0;
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_x = 4'd0; cmd_y = 4'd0; cmd_color = 1'b0;
        test_reset();
        test_clear();
        test_place_black();
        test_place_white();
        test_erase();
        test_invalid();
        test_back_to_back();
        test_reset_mid_clear();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gb_board_painter.md
Name: gb_board_painter

Overview:
- Write-side master for the 12-bit RGB framebuffer that the VGA display path reads. It drives the framebuffer write port (waddr/wdata/we) in the game clock domain.
- Accepts drawing commands from game logic: full-board clear, place stone, erase stone. It rasterises each command into one pixel write per cycle.
- The framebuffer is FB_W x FB_H pixels, row-major. The 15x15 board uses 8x8-pixel cells with the top-left corner at (X0,Y0).
- Cursor overlay is not drawn here; the display path handles it.

Parameters:
DW, 15, framebuffer address width
FB_W, 200, framebuffer width in pixels
FB_H, 150, framebuffer height in pixels
X0, 40, board origin x in pixels
Y0, 15, board origin y in pixels

Ports:
clk  in  1  single clock; framebuffer write clock
rst  in  1  asynchronous, active-high reset
cmd_valid  in  1  command request
cmd_ready  out  1  high when a command can be accepted
cmd_op  in  2  00 clear, 01 place stone, 10 erase stone, 11 reserved
cmd_x  in  4  cell column, 0..14
cmd_y  in  4  cell row, 0..14
cmd_color  in  1  0 black, 1 white (place only)
waddr  out  DW  framebuffer write address
wdata  out  12  framebuffer write data, RGB444
we  out  1  framebuffer write enable
busy  out  1  command in progress
done  out  1  one-cycle pulse when a command completes
cmd_err  out  1  one-cycle pulse, coincident with done, for a rejected command

Behaviour:
- Reset values:
  - waddr=0, wdata=0, we=0, busy=0, done=0, cmd_err=0, cmd_ready=1.
  - State is IDLE; all counters are 0.
- Reset is asynchronous: asserting rst mid-command drops we in the same instant and abandons the command. Partially written pixels stay in the framebuffer.
- State machine: IDLE, CLEAR, CELL, FIN. Outputs are registered.
- cmd_ready=1 only in IDLE. A command is accepted when cmd_valid & cmd_ready on a clk edge; cmd_* fields are latched at that edge. cmd_valid outside IDLE is ignored.
- IDLE -> CLEAR: on accepted op 00.
- IDLE -> CELL: on accepted op 01 or 10 with cmd_x<=14 and cmd_y<=14.
- IDLE -> FIN: on accepted op 11, or cmd_x>14, or cmd_y>14.
  - No writes occur.
  - cmd_err=1 together with done.
- First write: we=1 on the cycle after acceptance. Exactly one pixel is written per cycle with no gaps.
- waddr = py*FB_W + px, truncated to DW bits.
- CLEAR:
  - Visits every pixel row-major: px 0..FB_W-1 inner, py 0..FB_H-1 outer. That is FB_W*FB_H writes.
  - px counter wraps at FB_W-1 and increments py.
  - After pixel (FB_W-1, FB_H-1), go to FIN.
- CELL:
  - Writes 64 pixels of cell (cx,cy): dx 0..7 inner, dy 0..7 outer.
  - Pixel position: px = X0+8*cx+dx, py = Y0+8*cy+dy.
  - After dx=7, dy=7, go to FIN.
- FIN:
  - Lasts one cycle: we=0, done=1, busy=0. Then return to IDLE.
  - Throughput: the next command can be accepted at the end of the FIN cycle, so cmd_ready rises the cycle after done.
- busy=1 in CLEAR, CELL and FIN-preceding cycles, i.e. from the cycle after acceptance through the last write.
- Pixel colour, cell background (cell pixel at dx,dy):
  - Grid colour 12'h000 if dx==3 or dy==3.
  - Otherwise board colour 12'hDA6.
- Pixel colour, CLEAR:
  - Inside the board area (X0<=px<X0+120, Y0<=py<Y0+120): cell background, using dx=(px-X0)%8 and dy=(py-Y0)%8. Implement with counters, not dividers.
  - Outside the board area: border colour 12'h333.
- Stone mask: a pixel is outside the stone if any of:
  - dy in {0,7} and dx in {0,1,6,7}
  - dy in {1,6} and dx in {0,7}
  - Every other pixel is inside the stone.
- Place (op 01): inside-mask pixels get 12'h111 (black) or 12'hEEE (white). Outside-mask pixels get the cell background.
- Erase (op 10): all 64 pixels get the cell background. cmd_color is ignored.
- Place over an existing stone overwrites it. There is no occupancy tracking.

Test Plan:
- Reset, then idle 5 cycles -> we=0, cmd_ready=1, busy=0, done=0.
- Clear:
  - Exactly 30000 we cycles with contiguous addresses 0..29999; done pulse one cycle after the last write.
  - addr 0 = 12'h333, addr 3040 (40,15) = 12'hDA6, addr 3043 (43,15) = 12'h000, addr 29999 = 12'h333.
- Place black at (0,0):
  - 64 writes; first waddr=3040 with wdata 12'hDA6; dx=3,dy=0 gives 12'h000.
  - dx=3,dy=3 (addr 3643) gives 12'h111; dx=2,dy=1 (addr 3242) gives 12'h111; dx=1,dy=0 (addr 3041) gives 12'hDA6.
- Place white at (14,14):
  - First waddr=25552, last waddr=26959.
  - dx=4,dy=4 (addr 26356) gives 12'hEEE.
- Erase (0,0) after the place -> 64 writes with no 12'h111 values; addr 3643 = 12'h000.
- Invalid command, cmd_x=15 -> zero we cycles; done=1 and cmd_err=1 on the same single cycle; cmd_ready back to 1 the next cycle.
- cmd_valid held high with back-to-back commands:
  - Second command is accepted only in IDLE.
  - cmd_valid pulsed while busy during a clear is ignored; total writes remain 30000.
- Assert rst at write 1000 of a clear -> we=0 immediately; after release, cmd_ready=1 and no further writes occur.
